// File: rtl/led_slot_arbiter.sv
// LED slot arbiter: four requesters share a 4-bit LED display in round-robin
// slots. A free-running prescaler produces a slow tick; the controller only
// moves on ticks, showing a heartbeat while idle and a latched pattern while
// a requester owns the LEDs.
module led_slot_arbiter #(
  parameter int unsigned PRESCALE_W = 21,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] pat,
  output logic [3:0]  led,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        tick
);

  typedef enum logic {StIdle, StShow} state_e;

  localparam logic [PRESCALE_W-1:0] PrescOne = PRESCALE_W'(1);
  localparam logic [7:0]            HoldLast = 8'(HOLD_TICKS - 1);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic                  tick_q, tick_d;
  state_e                state_q, state_d;
  logic                  hb_q, hb_d;
  logic [7:0]            hold_q, hold_d;
  logic [1:0]            last_q, last_d;
  logic [3:0]            pat_q, pat_d;
  logic [3:0]            led_q, led_d;
  logic [3:0]            gnt_q, gnt_d;
  logic [3:0]            done_q, done_d;

  logic                  found;
  logic [1:0]            pick;
  logic                  slot_end;

  // Prescaler: tick is registered, so it is high the cycle after all-ones.
  always_comb begin
    presc_d = presc_q + PrescOne;
    tick_d  = &presc_q;
  end

  // Round-robin search starting just after the most recently granted index.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int k = 0; k < 4; k++) begin
      cand = last_q + 2'(k + 1);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The slot ends on a tick when the owner dropped its request or the hold ran out.
  always_comb begin
    slot_end = tick_q && (!req[last_q] || (hold_q == HoldLast));
  end

  // Controller next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    hb_d    = hb_q;
    hold_d  = hold_q;
    last_d  = last_q;
    pat_d   = pat_q;
    led_d   = led_q;
    gnt_d   = gnt_q;
    done_d  = 4'b0000;
    unique case (state_q)
      StIdle: begin
        gnt_d = 4'b0000;
        led_d = {hb_q, 3'b000};
        if (tick_q) begin
          hb_d  = ~hb_q;
          led_d = {~hb_q, 3'b000};
          if (found) begin
            state_d = StShow;
            pat_d   = pat[{pick, 2'b00} +: 4];
            led_d   = pat[{pick, 2'b00} +: 4];
            gnt_d   = 4'b0001 << pick;
            hold_d  = 8'd0;
            last_d  = pick;
          end
        end
      end
      StShow: begin
        // Pattern was latched at grant; live pat changes never reach the LEDs.
        led_d = pat_q;
        if (tick_q) begin
          hold_d = hold_q + 8'd1;
          if (slot_end) begin
            done_d  = gnt_q;
            gnt_d   = 4'b0000;
            led_d   = {hb_q, 3'b000};
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers; last resets to 3 so the first grant favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      state_q <= StIdle;
      hb_q    <= 1'b0;
      hold_q  <= 8'd0;
      last_q  <= 2'd3;
      pat_q   <= 4'b0000;
      led_q   <= 4'b0000;
      gnt_q   <= 4'b0000;
      done_q  <= 4'b0000;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      state_q <= state_d;
      hb_q    <= hb_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign gnt  = gnt_q;
  assign done = done_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_slot_arbiter.sv
// Bench for led_slot_arbiter with a short prescaler (tick every 8 clocks) and
// two-tick slots. Each vector is applied ahead of a tick; the expected outputs
// for the cycle after that tick go through a scoreboard queue.
module tb_led_slot_arbiter;

  localparam int unsigned PW = 3;
  localparam int unsigned HT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] pat;
  logic [3:0]  led;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        tick;

  always #5 clk = ~clk;

  led_slot_arbiter #(
    .PRESCALE_W(PW),
    .HOLD_TICKS(HT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .pat (pat),
    .led (led),
    .gnt (gnt),
    .done(done),
    .tick(tick)
  );

  typedef struct {
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  gnt;
    logic [3:0]  led;
    logic [3:0]  done;
  } vec_t;

  typedef struct {
    int         id;
    logic [3:0] gnt;
    logic [3:0] led;
    logic [3:0] done;
  } exp_t;

  localparam int NumVec = 28;

  vec_t vecs [NumVec];
  exp_t sb [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cycles = 0;
  int tick_cyc = 0;
  int prev_tick_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done != 4'b0000) done_cycles <= done_cycles + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic [3:0] r, input logic [15:0] p,
                      input logic [3:0] g, input logic [3:0] l, input logic [3:0] d);
    vecs[i] = '{r, p, g, l, d};
  endtask

  // Bounded wait for the next cycle in which tick is high (sampled at negedge).
  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick) begin
        ok = 1'b1;
        prev_tick_cyc = tick_cyc;
        tick_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic apply(input int i);
    bit   ok;
    exp_t e;
    req = vecs[i].req;
    pat = vecs[i].pat;
    sb.push_back('{i, vecs[i].gnt, vecs[i].led, vecs[i].done});
    wait_tick(ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL v%0d tick_timeout: got no tick, expected one within 40 clocks", i);
    end
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("v%0d gnt", e.id), {12'h0, gnt}, {12'h0, e.gnt});
    check($sformatf("v%0d led", e.id), {12'h0, led}, {12'h0, e.led});
    check($sformatf("v%0d done", e.id), {12'h0, done}, {12'h0, e.done});
    check($sformatf("v%0d gnt_onehot0", e.id), {15'h0, $onehot0(gnt)}, 16'h1);
    if (e.done != 4'b0000) begin
      @(negedge clk);
      check($sformatf("v%0d done_one_cycle", e.id), {12'h0, done}, 16'h0);
    end
  endtask

  initial begin
    bit ok;
    int n0;

    // Idle heartbeat, then single requester A for a full two-tick slot.
    setv(0,  4'h0, 16'h0000, 4'h0, 4'h8, 4'h0);
    setv(1,  4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
    setv(2,  4'h0, 16'h0000, 4'h0, 4'h8, 4'h0);
    setv(3,  4'h0, 16'h0000, 4'h0, 4'h0, 4'h0);
    setv(4,  4'h1, 16'h000A, 4'h1, 4'hA, 4'h0);
    setv(5,  4'h1, 16'h000A, 4'h1, 4'hA, 4'h0);
    setv(6,  4'h1, 16'h000A, 4'h0, 4'h8, 4'h1);
    setv(7,  4'h0, 16'h000A, 4'h0, 4'h0, 4'h0);
    // All four requesting after a reset: grants 0,1,2,3,0.
    setv(8,  4'hF, 16'h7531, 4'h1, 4'h1, 4'h0);
    setv(9,  4'hF, 16'h7531, 4'h1, 4'h1, 4'h0);
    setv(10, 4'hF, 16'h7531, 4'h0, 4'h8, 4'h1);
    setv(11, 4'hF, 16'h7531, 4'h2, 4'h3, 4'h0);
    setv(12, 4'hF, 16'h7531, 4'h2, 4'h3, 4'h0);
    setv(13, 4'hF, 16'h7531, 4'h0, 4'h0, 4'h2);
    setv(14, 4'hF, 16'h7531, 4'h4, 4'h5, 4'h0);
    setv(15, 4'hF, 16'h7531, 4'h4, 4'h5, 4'h0);
    setv(16, 4'hF, 16'h7531, 4'h0, 4'h8, 4'h4);
    setv(17, 4'hF, 16'h7531, 4'h8, 4'h7, 4'h0);
    setv(18, 4'hF, 16'h7531, 4'h8, 4'h7, 4'h0);
    setv(19, 4'hF, 16'h7531, 4'h0, 4'h0, 4'h8);
    setv(20, 4'hF, 16'h7531, 4'h1, 4'h1, 4'h0);
    setv(21, 4'hF, 16'h7531, 4'h1, 4'h1, 4'h0);
    setv(22, 4'hF, 16'h7531, 4'h0, 4'h8, 4'h1);
    // Requester 2 granted, then early release while others request.
    setv(23, 4'h4, 16'h0600, 4'h4, 4'h6, 4'h0);
    setv(24, 4'hB, 16'h9F00, 4'h0, 4'h0, 4'h4);
    setv(25, 4'hB, 16'h9F00, 4'h8, 4'h9, 4'h0);
    setv(26, 4'h0, 16'h9F00, 4'h0, 4'h8, 4'h8);
    // Requester 1 granted ahead of the mid-slot reset.
    setv(27, 4'h2, 16'h00C0, 4'h2, 4'hC, 4'h0);

    rst = 1'b1;
    req = 4'h0;
    pat = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset led", {12'h0, led}, 16'h0);
    check("reset gnt", {12'h0, gnt}, 16'h0);
    check("reset done", {12'h0, done}, 16'h0);
    check("reset tick", {15'h0, tick}, 16'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      apply(i);
      if (i >= 1 && i <= 3) check($sformatf("tick_period %0d", i),
                                  16'(tick_cyc - prev_tick_cyc), 16'd8);
    end

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 8; i < 23; i++) apply(i);

    apply(23);
    pat = 16'h0F00;
    repeat (2) @(negedge clk);
    check("pat_ignored led", {12'h0, led}, 16'h6);
    for (int i = 24; i < 28; i++) apply(i);

    // Reset mid-slot of requester 1: outputs clear at once, no done pulse.
    repeat (2) @(negedge clk);
    n0 = done_cycles;
    rst = 1'b1;
    req = 4'h0;
    #1;
    check("midrst led", {12'h0, led}, 16'h0);
    check("midrst gnt", {12'h0, gnt}, 16'h0);
    check("midrst done", {12'h0, done}, 16'h0);
    check("midrst tick", {15'h0, tick}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    wait_tick(ok);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL post_reset tick_timeout: got no tick, expected one within 40 clocks");
    end
    // Request rises inside the tick cycle and still wins that arbitration.
    req = 4'b0011;
    pat = 16'h00C7;
    @(negedge clk);
    check("post_reset gnt", {12'h0, gnt}, 16'h1);
    check("post_reset led", {12'h0, led}, 16'h7);
    check("post_reset done", {12'h0, done}, 16'h0);
    check("no_done_after_reset", 16'(done_cycles - n0), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of test, expected one before 1 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/led_slot_arbiter.md
LED_SLOT_ARBITER -- requirements
Module: led_slot_arbiter

Interface
REQ-001 Parameter PRESCALE_W, default 21, width of the free-running tick prescaler (one tick per 2^PRESCALE_W clocks).
REQ-002 Parameter HOLD_TICKS, default 8, number of ticks one granted requester owns the LEDs (legal range 1..255).
REQ-003 Port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  4  per-requester display request, level-sensitive, bit i = requester i.
REQ-006 Port pat  input  16  display patterns; pat[4i+3:4i] belongs to requester i.
REQ-007 Port led  output  4  registered LED drive.
REQ-008 Port gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-009 Port done  output  4  registered one-cycle pulse on bit i when requester i's slot ends.
REQ-010 Port tick  output  1  registered one-cycle prescaler tick, exported for status use.

Function
REQ-011 The prescaler shall be a PRESCALE_W-bit counter that increments every clock, wraps to 0, and asserts tick for exactly the one cycle after the counter reaches all-ones.
REQ-012 The controller shall have two states, IDLE and SHOW, and shall change state only in a cycle where tick is 1.
REQ-013 In IDLE, a heartbeat flop shall toggle on every tick, and led shall equal {heartbeat, 3'b000}.
REQ-014 In IDLE, on a tick with req != 0, the arbiter shall grant the first requesting index searching round-robin from (last+1) mod 4, where last is the most recently granted index.
REQ-015 On grant, the controller shall latch that requester's 4-bit pattern, set gnt one-hot, clear the hold counter, update last, and enter SHOW; led shall show the latched pattern from the cycle after the tick.
REQ-016 In IDLE, on a tick with req == 0, the controller shall stay in IDLE with gnt = 0.
REQ-017 In SHOW, led shall hold the latched pattern; changes on pat after the grant shall be ignored.
REQ-018 In SHOW, each tick shall increment the 8-bit hold counter; the slot ends on the tick where the counter equals HOLD_TICKS-1.
REQ-019 In SHOW, if the granted requester's req bit is 0 when a tick occurs, the slot shall end on that tick (early release).
REQ-020 At slot end, the controller shall pulse done for the granted index for one cycle, clear gnt, and return to IDLE; led shall become {heartbeat, 3'b000} in the next cycle; re-arbitration shall occur no earlier than the next tick.
REQ-021 Requests from non-granted requesters during SHOW shall be held off and shall not change gnt, led or the hold counter.
REQ-022 A req bit that rises in the same cycle as a tick shall count as requesting for that tick's arbitration.
REQ-023 gnt shall never have more than one bit set, and done shall only pulse on the bit that was set in gnt in the previous cycle.

Reset
REQ-024 While rst is 1, the outputs shall be led = 0, gnt = 0, done = 0 and tick = 0, and the internal state shall be prescaler = 0, heartbeat = 0, hold counter = 0, last = 3, state = IDLE.
REQ-025 rst asserted mid-slot shall abort the slot immediately with no done pulse; after release, the first arbitration shall favour requester 0.

Verification (PRESCALE_W=3, HOLD_TICKS=2: tick every 8 clocks)
REQ-026 Reset, then req=0 for 4 ticks -> gnt=0, done=0; led toggles 4'b1000/4'b0000 on each tick; tick period is exactly 8 clocks.
REQ-027 req=4'b0001, pat[3:0]=4'hA -> gnt=4'b0001 after the first tick, led=4'hA for 2 ticks, one done[0] pulse, then IDLE.
REQ-028 req=4'b1111 held, with distinct patterns -> grants run 0,1,2,3,0 on successive slots, each slot separated by one IDLE tick period, with no index skipped.
REQ-029 Requester 2 is granted, then req[2] drops mid-slot -> slot ends on the next tick, done[2] pulses, and pat changes during the slot never reach led.
REQ-030 rst is pulsed during SHOW of requester 1 -> all outputs 0 immediately and no done pulse; with req=4'b0011 after release, the first grant goes to 0.
